// File: rtl/c5_negate_pkg.sv
// rtl/c5_negate_pkg.sv - shared types and constants for the c5 sign-operation pipeline
package c5_negate_pkg;

    localparam int C5_NEG_MODE_W = 2;

    typedef enum logic [C5_NEG_MODE_W-1:0] {
        C5_NEG_PASS = 2'd0,
        C5_NEG_NEG  = 2'd1,
        C5_NEG_ABS  = 2'd2,
        C5_NEG_NABS = 2'd3
    } c5_neg_mode_e;

endpackage

// File: rtl/c5_negate_stage.sv
// rtl/c5_negate_stage.sv - one handshaked register slice holding {valid, payload}
module c5_negate_stage #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_tvalid,
    input  logic [W-1:0] s_tdata,
    input  logic         m_tready,
    output logic         m_tvalid,
    output logic [W-1:0] m_tdata
);

    logic load;

    // Loads when empty or when the downstream side drains this slice this cycle.
    assign load = !m_tvalid || m_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
        end else if (load) begin
            m_tvalid <= s_tvalid;
            // Payload only moves with a real operand so the output holds its last value when idle.
            if (s_tvalid) begin
                m_tdata <= s_tdata;
            end
        end
    end

endmodule

// File: rtl/c5_negate_pipe.sv
// rtl/c5_negate_pipe.sv - pipelined pass/neg/abs/nabs with overflow; C5_NEGATE_SAT_EN selects saturation
module c5_negate_pipe
    import c5_negate_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                     I_clk,
    input  logic                     I_reset_n,
    input  logic                     I_valid,
    output logic                     O_ready,
    input  logic [WIDTH-1:0]         I_a,
    input  logic [C5_NEG_MODE_W-1:0] I_mode,
    output logic                     O_valid,
    input  logic                     I_ready,
    output logic [WIDTH-1:0]         O_result,
    output logic                     O_ovf
);

    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

`ifdef C5_NEGATE_SAT_EN
    localparam logic [WIDTH-1:0] OVF_RESULT = ~MIN;
`else
    localparam logic [WIDTH-1:0] OVF_RESULT = MIN;
`endif

    c5_neg_mode_e     mode;
    logic [WIDTH-1:0] neg;
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             is_min;

    always_comb begin
        mode   = c5_neg_mode_e'(I_mode);
        neg    = ~I_a + ONE;
        is_min = (I_a == MIN);
        res    = I_a;
        ovf    = 1'b0;
        case (mode)
            C5_NEG_PASS: res = I_a;
            C5_NEG_NEG: begin
                res = neg;
                ovf = is_min;
            end
            C5_NEG_ABS: begin
                res = I_a[WIDTH-1] ? neg : I_a;
                ovf = is_min;
            end
            C5_NEG_NABS: res = I_a[WIDTH-1] ? I_a : neg;
        endcase
        if (ovf) begin
            res = OVF_RESULT;
        end
    end

    logic [STAGES:0]   vld;
    logic [WIDTH:0]    pay [STAGES+1];
    logic [STAGES-1:0] rdy;

    assign vld[0] = I_valid;
    assign pay[0] = {ovf, res};

    // Ready of stage k is true when any stage from k to the output is empty or I_ready is high;
    // built from registered valids so there is no combinational loop.
    always_comb begin : ready_chain
        logic r;
        r   = I_ready;
        rdy = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            r      = !vld[k+1] || r;
            rdy[k] = r;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic m_ready;
        if (k == STAGES - 1) begin : g_last
            assign m_ready = I_ready;
        end else begin : g_mid
            assign m_ready = rdy[k+1];
        end

        c5_negate_stage #(
            .W(WIDTH + 1)
        ) u_stage (
            .clk     (I_clk),
            .rst_n   (I_reset_n),
            .s_tvalid(vld[k]),
            .s_tdata (pay[k]),
            .m_tready(m_ready),
            .m_tvalid(vld[k+1]),
            .m_tdata (pay[k+1])
        );
    end

    assign O_ready             = rdy[0];
    assign O_valid             = vld[STAGES];
    assign {O_ovf, O_result}   = pay[STAGES];

endmodule

// File: tb/tb_c5_negate_pipe.sv
// tb/tb_c5_negate_pipe.sv - directed self-checking bench for c5_negate_pipe (STAGES 2, 1 and 4)
module tb_c5_negate_pipe;
    import c5_negate_pkg::*;

`ifdef C5_NEGATE_SAT_EN
    localparam logic [31:0] OVF_RES = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] OVF_RES = 32'h8000_0000;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        m_iv, m_or, m_ov, m_ir, m_ovf;
    logic [31:0] m_a, m_res;
    logic [1:0]  m_mode;

    logic        s1_iv, s1_or, s1_ov, s1_ir, s1_ovf;
    logic [31:0] s1_a, s1_res;
    logic [1:0]  s1_mode;

    logic        s4_iv, s4_or, s4_ov, s4_ir, s4_ovf;
    logic [31:0] s4_a, s4_res;
    logic [1:0]  s4_mode;

    c5_negate_pipe #(.WIDTH(32), .STAGES(2)) u_dut (
        .I_clk(clk), .I_reset_n(rst_n), .I_valid(m_iv), .O_ready(m_or), .I_a(m_a),
        .I_mode(m_mode), .O_valid(m_ov), .I_ready(m_ir), .O_result(m_res), .O_ovf(m_ovf)
    );

    c5_negate_pipe #(.WIDTH(32), .STAGES(1)) u_dut_s1 (
        .I_clk(clk), .I_reset_n(rst_n), .I_valid(s1_iv), .O_ready(s1_or), .I_a(s1_a),
        .I_mode(s1_mode), .O_valid(s1_ov), .I_ready(s1_ir), .O_result(s1_res), .O_ovf(s1_ovf)
    );

    c5_negate_pipe #(.WIDTH(32), .STAGES(4)) u_dut_s4 (
        .I_clk(clk), .I_reset_n(rst_n), .I_valid(s4_iv), .O_ready(s4_or), .I_a(s4_a),
        .I_mode(s4_mode), .O_valid(s4_ov), .I_ready(s4_ir), .O_result(s4_res), .O_ovf(s4_ovf)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Backpressure scenario, one entry per cycle.
    logic        bp_ir  [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        bp_iv  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] bp_a   [9] = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0};
    logic        bp_or  [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        bp_ov  [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] bp_res [9] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0};

    logic [31:0] st_a   [4] = '{32'd7, 32'd1, 32'd2, 32'd3};
    logic [31:0] st_exp [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic run_one(input string tag, input logic [1:0] mode, input logic [31:0] a,
                           input logic [31:0] exp_r, input logic exp_o);
        m_iv = 1'b1; m_a = a; m_mode = mode;
        tick();
        m_iv = 1'b0;
        chk({tag, "/early"}, 64'(m_ov), 64'd0);
        tick();
        chk({tag, "/valid"}, 64'(m_ov), 64'd1);
        chk({tag, "/res"}, 64'(m_res), 64'(exp_r));
        chk({tag, "/ovf"}, 64'(m_ovf), 64'(exp_o));
        tick();
        chk({tag, "/drain"}, 64'(m_ov), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        m_iv = 1'b0; m_a = '0; m_mode = '0; m_ir = 1'b1;
        s1_iv = 1'b0; s1_a = '0; s1_mode = '0; s1_ir = 1'b1;
        s4_iv = 1'b0; s4_a = '0; s4_mode = '0; s4_ir = 1'b1;
        tick();
        tick();
        chk("rst/valid", 64'(m_ov), 64'd0);
        chk("rst/res", 64'(m_res), 64'd0);
        chk("rst/ovf", 64'(m_ovf), 64'd0);
        chk("rst/s1_valid", 64'(s1_ov), 64'd0);
        chk("rst/s4_valid", 64'(s4_ov), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst/ready", 64'(m_or), 64'd1);
        tick();

        // NEG 3 then NEG 2 back to back, each visible two cycles after presentation
        m_iv = 1'b1; m_a = 32'd3; m_mode = C5_NEG_NEG;
        tick();
        m_a = 32'd2;
        chk("neg32/lat1", 64'(m_ov), 64'd0);
        tick();
        m_iv = 1'b0;
        chk("neg3/valid", 64'(m_ov), 64'd1);
        chk("neg3/res", 64'(m_res), 64'hFFFF_FFFD);
        chk("neg3/ovf", 64'(m_ovf), 64'd0);
        tick();
        chk("neg2/valid", 64'(m_ov), 64'd1);
        chk("neg2/res", 64'(m_res), 64'hFFFF_FFFE);
        tick();
        chk("neg2/drain", 64'(m_ov), 64'd0);

        run_one("abs_m2",    C5_NEG_ABS,  32'hFFFF_FFFE, 32'h0000_0002, 1'b0);
        run_one("nabs_5",    C5_NEG_NABS, 32'h0000_0005, 32'hFFFF_FFFB, 1'b0);
        run_one("nabs_m5",   C5_NEG_NABS, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 1'b0);
        run_one("pass",      C5_NEG_PASS, 32'h1234_5678, 32'h1234_5678, 1'b0);
        run_one("nabs_0",    C5_NEG_NABS, 32'h0000_0000, 32'h0000_0000, 1'b0);
        run_one("neg_0",     C5_NEG_NEG,  32'h0000_0000, 32'h0000_0000, 1'b0);
        run_one("neg_max",   C5_NEG_NEG,  32'h7FFF_FFFF, 32'h8000_0001, 1'b0);
        run_one("abs_max",   C5_NEG_ABS,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        run_one("neg_min",   C5_NEG_NEG,  32'h8000_0000, OVF_RES,       1'b1);
        run_one("abs_min",   C5_NEG_ABS,  32'h8000_0000, OVF_RES,       1'b1);
        run_one("nabs_min",  C5_NEG_NABS, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_one("pass_min",  C5_NEG_PASS, 32'h8000_0000, 32'h8000_0000, 1'b0);

        // Backpressure: I_ready low for cycles 1..3 while NEG 1..4 stream in
        m_mode = C5_NEG_NEG;
        for (int c = 0; c < 9; c++) begin
            m_ir = bp_ir[c]; m_iv = bp_iv[c]; m_a = bp_a[c];
            #1;
            chk($sformatf("bp%0d/ready", c), 64'(m_or), 64'(bp_or[c]));
            chk($sformatf("bp%0d/valid", c), 64'(m_ov), 64'(bp_ov[c]));
            if (bp_ov[c]) begin
                chk($sformatf("bp%0d/res", c), 64'(m_res), 64'(bp_res[c]));
            end
            tick();
        end
        m_iv = 1'b0; m_ir = 1'b1;

        // Reset with two operands in flight
        m_ir = 1'b0; m_iv = 1'b1; m_a = 32'd9;
        tick();
        m_a = 32'd10;
        tick();
        m_iv = 1'b0;
        chk("rstmid/full", 64'(m_ov), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid/valid", 64'(m_ov), 64'd0);
        chk("rstmid/res", 64'(m_res), 64'd0);
        tick();
        rst_n = 1'b1;
        m_ir = 1'b1;
        #1;
        chk("rstmid/ready", 64'(m_or), 64'd1);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("rstmid/idle%0d", c), 64'(m_ov), 64'd0);
        end
        run_one("post_rst", C5_NEG_NEG, 32'd7, 32'hFFFF_FFF9, 1'b0);

        // STAGES=1 and STAGES=4: NEG 7 then NEG 1..3 at full rate
        s1_mode = C5_NEG_NEG; s4_mode = C5_NEG_NEG;
        for (int c = 0; c < 9; c++) begin
            s1_iv = (c < 4); s4_iv = (c < 4);
            s1_a = (c < 4) ? st_a[c] : 32'd0;
            s4_a = (c < 4) ? st_a[c] : 32'd0;
            #1;
            chk($sformatf("s1_%0d/ready", c), 64'(s1_or), 64'd1);
            chk($sformatf("s4_%0d/ready", c), 64'(s4_or), 64'd1);
            chk($sformatf("s1_%0d/valid", c), 64'(s1_ov), 64'(c >= 1 && c <= 4));
            chk($sformatf("s4_%0d/valid", c), 64'(s4_ov), 64'(c >= 4 && c <= 7));
            if (c >= 1 && c <= 4) begin
                chk($sformatf("s1_%0d/res", c), 64'(s1_res), 64'(st_exp[c-1]));
            end
            if (c >= 4 && c <= 7) begin
                chk($sformatf("s4_%0d/res", c), 64'(s4_res), 64'(st_exp[c-4]));
            end
            tick();
        end
        s1_iv = 1'b0; s4_iv = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/c5_negate_pipe.md
# c5_negate_pipe

Parametrised, pipelined successor to the combinational two's-complement negator. It performs one of four sign operations on a WIDTH-bit operand: pass, negate, absolute value, or negative absolute value. Each operation reports overflow. Results pass through a configurable number of register stages with a valid/ready handshake, so the block can sit directly in the C5 datapath between handshaked producers and consumers.

## Interface
Parameters:
- WIDTH, 32: operand and result width in bits; legal range 2..64.
- STAGES, 2: number of pipeline register stages; legal range 1..4.

Ports:
- I_clk  in  1  sole clock; all state updates on the rising edge.
- I_reset_n  in  1  asynchronous, active-low reset.
- I_valid  in  1  upstream operand valid.
- O_ready  out  1  block can accept an operand this cycle.
- I_a  in  WIDTH  operand, two's complement.
- I_mode  in  2  operation select: 0 PASS, 1 NEG, 2 ABS, 3 NABS.
- O_valid  out  1  result valid.
- I_ready  in  1  downstream accepts the result this cycle.
- O_result  out  WIDTH  result, two's complement.
- O_ovf  out  1  result was not representable in WIDTH bits.

## Operation
- Transfer rules:
  - Input transfer occurs when I_valid && O_ready.
  - Output transfer occurs when O_valid && I_ready.
- Arithmetic is evaluated combinationally on I_a and I_mode ahead of stage 1. Only the result and ovf are registered.
- Operations (MIN = 1 followed by WIDTH-1 zeros; MAX = 0 followed by WIDTH-1 ones):
  - PASS: result = a, ovf = 0.
  - NEG: result = ~a + 1. ovf = 1 only when a == MIN.
  - ABS: result = a[WIDTH-1] ? -a : a. ovf = 1 only when a == MIN.
  - NABS: result = a[WIDTH-1] ? a : -a. Never overflows; NABS(0) = 0.
- On overflow the result depends on C5_NEGATE_SAT_EN (see Configuration).
- Each stage holds {valid, result, ovf}.
  - A stage loads when it is empty or when its downstream stage or port consumes this cycle.
  - Stage k ready = !valid_k || ready_(k+1). The last stage uses I_ready in place of ready_(k+1).
  - O_ready = stage-1 ready.
- The block has no internal state machine beyond the per-stage valid bits. Valid bits are the only control state.
- Ordering is strict FIFO order. No operand is ever dropped or duplicated.

## Timing
- Reset (asynchronous, takes effect immediately): all stage valid bits = 0, so O_valid = 0, O_result = 0, O_ovf = 0.
- After reset release: O_ready = 1 in the first cycle.
- Latency: an operand accepted at edge n appears on O_valid/O_result after edge n+STAGES-1, i.e. it is visible STAGES cycles after it was presented. This holds provided there is no backpressure.
- Throughput: one operand per cycle while I_ready is held high.
- Stall behaviour:
  - While O_valid && !I_ready, O_result and O_ovf are held stable.
  - Upstream stages fill. O_ready falls only when all STAGES stages are full.
- Full pipe with I_ready = 1: the block accepts and emits in the same cycle (pass-through ready).
- O_ready depends combinationally on I_ready. This path is documented and accepted.
- A reset asserted mid-stream discards all in-flight operands. Nothing is emitted until a new operand is accepted after release.
- While O_valid = 0, O_result holds its last value (or 0 after reset). Consumers must ignore O_result in that state.

## Configuration
- Macro: C5_NEGATE_SAT_EN.
- Defined: on overflow, O_result = MAX and O_ovf = 1. This is saturating behaviour.
- Undefined: on overflow, O_result = MIN (wrap-around, identical to plain two's-complement negation) and O_ovf = 1.
- O_ovf is generated in both builds.

## Structure
- Package c5_negate_pkg contains:
  - the mode enum (C5_NEG_PASS, C5_NEG_NEG, C5_NEG_ABS, C5_NEG_NABS);
  - the constant C5_NEG_MODE_W = 2.
- Sub-module c5_negate_stage: one handshaked register slice (valid, WIDTH+1 payload, ready chain).
  - The top module computes the arithmetic.
  - It instantiates STAGES slices in a generate loop.

## Test plan
All scenarios use WIDTH=32, STAGES=2 unless noted.
- NEG 3, then NEG 2, with I_ready held at 1 -> O_result 0xFFFFFFFD then 0xFFFFFFFE, each 2 cycles after input, O_ovf 0.
- ABS 0xFFFFFFFE -> 0x00000002. NABS 5 -> 0xFFFFFFFB. NABS 0xFFFFFFFB -> 0xFFFFFFFB. PASS 0x12345678 -> unchanged.
- NEG 0x80000000 and ABS 0x80000000:
  - without the macro -> 0x80000000, O_ovf 1;
  - with C5_NEGATE_SAT_EN -> 0x7FFFFFFF, O_ovf 1.
- Backpressure: stream NEG 1, 2, 3, 4 back-to-back with I_ready low for 3 cycles mid-stream -> outputs are exactly 0xFFFFFFFF, FFFFFFFE, FFFFFFFD, FFFFFFFC in order. O_result is stable while stalled, and O_ready drops only when 2 results are held.
- Reset: assert I_reset_n low with 2 operands in flight -> O_valid 0 immediately. After release, no output until a new input arrives.
- STAGES=1 and STAGES=4 builds: NEG 7 -> 0xFFFFFFF9 with latency 1 and 4 cycles respectively. Full throughput is sustained with I_ready=1.
